// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
`timescale 1ns/1ps
package lsu_pkg;

  // Access size encodings
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // FSM state encodings
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_WR     = 3'd1;
  localparam state_t ST_RD     = 3'd2;
  localparam state_t ST_RDLAST = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  // Number of byte transactions for an access size (0 for reserved)
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SZ_BYTE: byte_count = 3'd1;
      SZ_HALF: byte_count = 3'd2;
      SZ_WORD: byte_count = 3'd4;
      default: byte_count = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of right-justified load bytes to 32 bits.
`timescale 1ns/1ps
module load_extend
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] bytes_in,
  output logic [31:0] result_c
);

  // Extend from the top bit of the sized value
  always_comb begin
    result_c = bytes_in;
    case (size)
      SZ_BYTE: result_c = {{24{sign_ext & bytes_in[7]}}, bytes_in[7:0]};
      SZ_HALF: result_c = {{16{sign_ext & bytes_in[15]}}, bytes_in[15:0]};
      default: result_c = bytes_in;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial, big-endian load/store initiator between MEM stage and data memory.
`timescale 1ns/1ps
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter bit          CHECK_ALIGN = 1'b1
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  signExt,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           writeData,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           readData,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [7:0]            memWriteData,
  output logic                  memRead,
  output logic                  memWrite,
  input  logic [7:0]            memReadData
);

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [1:0]            size_q, size_d;
  logic                  sext_q, sext_d;
  logic [31:0]           wsh_q, wsh_d;
  logic [23:0]           rsh_q, rsh_d;

  logic                  busy_d, done_d, err_d, mem_read_d, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [7:0]            mem_wdata_d;
  logic [31:0]           read_data_d;

  logic [2:0]            req_n_c;
  logic                  reject_c;
  logic [31:0]           wr_align_c;
  logic [1:0]            last_idx_c;
  logic [31:0]           ext_c;

  // Request decode: byte count, rejection, store data left-aligned so the first byte sits at [31:24]
  assign req_n_c    = byte_count(size);
  assign reject_c   = (size == SZ_RSVD) ||
                      (CHECK_ALIGN && (((size == SZ_HALF) && address[0]) ||
                                       ((size == SZ_WORD) && (address[1:0] != 2'b00))));
  assign wr_align_c = writeData << {3'd4 - req_n_c, 3'b000};
  assign last_idx_c = 2'(byte_count(size_q) - 3'd1);

  load_extend u_load_extend (
    .size     (size_q),
    .sign_ext (sext_q),
    .bytes_in ({rsh_q, memReadData}),
    .result_c (ext_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    sext_d      = sext_q;
    wsh_d       = wsh_q;
    rsh_d       = rsh_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = memAddr;
    mem_wdata_d = memWriteData;
    read_data_d = readData;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          size_d = size;
          sext_d = signExt;
          cnt_d  = 2'd0;
          rsh_d  = 24'd0;
          if (reject_c) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (we) begin
            state_d     = ST_WR;
            mem_write_d = 1'b1;
            mem_addr_d  = address;
            mem_wdata_d = wr_align_c[31:24];
            wsh_d       = wr_align_c << 8;
          end else begin
            state_d    = ST_RD;
            mem_read_d = 1'b1;
            mem_addr_d = address;
          end
        end
      end
      ST_WR: begin
        if (cnt_q == last_idx_c) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d       = cnt_q + 2'd1;
          mem_write_d = 1'b1;
          mem_addr_d  = memAddr + ADDR_WIDTH'(1);
          mem_wdata_d = wsh_q[31:24];
          wsh_d       = wsh_q << 8;
        end
      end
      ST_RD: begin
        if (cnt_q != 2'd0) begin
          rsh_d = {rsh_q[15:0], memReadData};
        end
        if (cnt_q == last_idx_c) begin
          state_d = ST_RDLAST;
        end else begin
          cnt_d      = cnt_q + 2'd1;
          mem_read_d = 1'b1;
          mem_addr_d = memAddr + ADDR_WIDTH'(1);
        end
      end
      ST_RDLAST: begin
        state_d     = ST_DONE;
        done_d      = 1'b1;
        read_data_d = ext_c;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 2'd0;
      size_q       <= 2'd0;
      sext_q       <= 1'b0;
      wsh_q        <= 32'd0;
      rsh_q        <= 24'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      readData     <= 32'd0;
      memAddr      <= '0;
      memWriteData <= 8'd0;
      memRead      <= 1'b0;
      memWrite     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      sext_q       <= sext_d;
      wsh_q        <= wsh_d;
      rsh_q        <= rsh_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
      readData     <= read_data_d;
      memAddr      <= mem_addr_d;
      memWriteData <= mem_wdata_d;
      memRead      <= mem_read_d;
      memWrite     <= mem_write_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic against a byte-array model.
`timescale 1ns/1ps
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_n, req, we, signExt;
  logic [1:0]    size;
  logic [AW-1:0] address;
  logic [31:0]   writeData;
  logic          busy, done, err;
  logic [31:0]   readData;
  logic [AW-1:0] memAddr;
  logic [7:0]    memWriteData;
  logic          memRead, memWrite;
  logic [7:0]    memReadData;

  bit [7:0]    mem     [4096];
  bit [7:0]    ref_mem [4096];
  int unsigned total  = 0;
  int unsigned passed = 0;
  logic [31:0] last_rd;

  load_store_unit #(.ADDR_WIDTH(AW), .CHECK_ALIGN(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .we           (we),
    .size         (size),
    .signExt      (signExt),
    .address      (address),
    .writeData    (writeData),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .readData     (readData),
    .memAddr      (memAddr),
    .memWriteData (memWriteData),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .memReadData  (memReadData)
  );

  always #5 clk = ~clk;

  // Data memory: writes on the strobe edge, read data one cycle after memRead
  always @(posedge clk) begin
    if (memWrite) mem[memAddr[11:0]] <= memWriteData;
    memReadData <= memRead ? mem[memAddr[11:0]] : 8'hxx;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  // Big-endian load from the reference memory, then extend arithmetically
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sx);
    longint unsigned v = 0;
    longint unsigned mask;
    int n = nbytes(sz);
    logic [31:0] ak;
    for (int k = 0; k < n; k++) begin
      ak = a + 32'(k);
      v  = (v << 8) | longint'(ref_mem[ak[11:0]]);
    end
    mask = (64'd1 << (8 * n)) - 64'd1;
    if (sx && (((v >> (8 * n - 1)) & 64'd1) != 0)) v = v | ~mask;
    return v[31:0];
  endfunction

  // Issue one request at the current negedge and check every cycle up to completion
  task automatic run_op(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d);
    int n, dexp;
    logic rej;
    logic [31:0] exp_rd, ak;
    longint unsigned v;
    n      = nbytes(sz);
    rej    = (n == 0) || (sz == SZ_HALF && a[0]) || (sz == SZ_WORD && a[1:0] != 2'b00);
    dexp   = rej ? 1 : (w ? n + 1 : n + 2);
    exp_rd = (rej || w) ? last_rd : model_load(a, sz, sx);
    v      = longint'(d) & ((64'd1 << (8 * n)) - 64'd1);
    we = w; size = sz; signExt = sx; address = a; writeData = d; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int c = 1; c <= dexp; c++) begin
      chk($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(1));
      chk($sformatf("%s done c%0d", tag, c), 32'(done), 32'(c == dexp));
      chk($sformatf("%s memWrite c%0d", tag, c), 32'(memWrite), 32'(!rej && w && c <= n));
      chk($sformatf("%s memRead c%0d", tag, c), 32'(memRead), 32'(!rej && !w && c <= n));
      chk($sformatf("%s excl c%0d", tag, c), 32'(memRead & memWrite), 32'(0));
      if (!rej && c <= n) begin
        chk($sformatf("%s memAddr c%0d", tag, c), memAddr, a + 32'(c - 1));
        if (w) chk($sformatf("%s wdata c%0d", tag, c), 32'(memWriteData),
                   32'((v >> (8 * (n - c))) & 64'hFF));
      end
      if (c == dexp) begin
        chk($sformatf("%s err", tag), 32'(err), 32'(rej));
        chk($sformatf("%s readData", tag), readData, exp_rd);
      end
      @(negedge clk);
    end
    chk($sformatf("%s idle busy", tag), 32'(busy), 32'(0));
    chk($sformatf("%s idle done", tag), 32'(done), 32'(0));
    if (!rej && w) begin
      for (int k = 0; k < n; k++) begin
        ak = a + 32'(k);
        ref_mem[ak[11:0]] = 8'((v >> (8 * (n - 1 - k))) & 64'hFF);
      end
    end
    last_rd = exp_rd;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; signExt = 1'b0;
    address = '0; writeData = 32'd0; last_rd = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy), 32'(0));
    chk("rst done", 32'(done), 32'(0));
    chk("rst err", 32'(err), 32'(0));
    chk("rst memRead", 32'(memRead), 32'(0));
    chk("rst memWrite", 32'(memWrite), 32'(0));
    chk("rst memAddr", memAddr, 32'd0);
    chk("rst memWriteData", 32'(memWriteData), 32'(0));
    chk("rst readData", readData, 32'd0);
    rst_n = 1'b1;

    run_op("sw10", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
    run_op("lw10", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    chk("lw10 value", last_rd, 32'hDEADBEEF);
    run_op("lb11", 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0);
    chk("lb11 value", last_rd, 32'hFFFFFFAD);
    run_op("lbu11", 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0);
    chk("lbu11 value", last_rd, 32'h000000AD);
    run_op("lh12", 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0);
    chk("lh12 value", last_rd, 32'hFFFFBEEF);
    run_op("sh13", 1'b1, SZ_HALF, 1'b0, 32'h13, 32'h1234);
    run_op("sz11", 1'b1, SZ_RSVD, 1'b0, 32'h10, 32'h1234);
    run_op("lwmis", 1'b0, SZ_WORD, 1'b1, 32'h12, 32'h0);
    chk("reject readData", readData, 32'hFFFFBEEF);

    // req held high: one sb every three cycles, never accepted in the done cycle
    we = 1'b1; size = SZ_BYTE; signExt = 1'b0; address = 32'h20; writeData = 32'h5A; req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk($sformatf("held busy c%0d", c), 32'(busy), 32'(c % 3 != 0));
      chk($sformatf("held done c%0d", c), 32'(done), 32'(c % 3 == 2));
      chk($sformatf("held memWrite c%0d", c), 32'(memWrite), 32'(c % 3 == 1));
      if (c % 3 == 1) chk($sformatf("held memAddr c%0d", c), memAddr, 32'h20);
    end
    req = 1'b0;
    @(negedge clk);
    chk("held idle busy", 32'(busy), 32'(0));
    ref_mem[12'h020] = 8'h5A;

    // Reset during the third cycle of a store
    run_op("sw40", 1'b1, SZ_WORD, 1'b0, 32'h40, 32'h11223344);
    we = 1'b1; size = SZ_WORD; address = 32'h40; writeData = 32'hAABBCCDD; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("abort memWrite c1", 32'(memWrite), 32'(1));
    @(negedge clk);
    chk("abort memAddr c2", memAddr, 32'h41);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort memWrite c3", 32'(memWrite), 32'(0));
    chk("abort busy c3", 32'(busy), 32'(0));
    chk("abort done c3", 32'(done), 32'(0));
    chk("abort readData", readData, 32'd0);
    for (int c = 4; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("abort done c%0d", c), 32'(done), 32'(0));
      chk($sformatf("abort memWrite c%0d", c), 32'(memWrite), 32'(0));
    end
    ref_mem[12'h040] = 8'hAA;
    ref_mem[12'h041] = 8'hBB;
    last_rd = 32'd0;
    run_op("lw40", 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
    chk("lw40 value", last_rd, 32'hAABB3344);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra;
      logic [1:0]  rs;
      ra = $urandom;
      rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      run_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)),
             ra, $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
